// File: rtl/multiplier_seq_if.sv
// Handshake and result bundle for multiplier_seq. The master drives the
// buttons and switches, and the slave (the multiplier) returns X:A:B and status.
interface multiplier_seq_if #(
  parameter int W = 8
);
  logic         clearALoadB;
  logic         run;
  logic [W-1:0] din;
  logic         xval;
  logic [W-1:0] aval;
  logic [W-1:0] bval;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output clearALoadB, run, din,
    input  xval, aval, bval, busy, done, ovf
  );

  modport slave (
    input  clearALoadB, run, din,
    output xval, aval, bval, busy, done, ovf
  );
endinterface

// File: rtl/multiplier_seq.sv
// Signed sequential shift-add multiplier: latched multiplicand S times register B into X:A:B.
// Define MULT_OVF_EN to build the registered overflow flag; otherwise ovf is tied low.
module multiplier_seq #(
  parameter int W = 8
) (
  input logic             clk_i,
  input logic             reset_i,
  multiplier_seq_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CLR, ADD, SHIFT} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   s_q, s_d;
  logic           x_q, x_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q;
  logic           done_q, done_d;
  logic [W:0]     sum;
  logic           load;
  logic           start;

  // A load takes priority over a Run edge in the same cycle.
  assign load  = (state_q == IDLE) && bus.clearALoadB;
  assign start = (state_q == IDLE) && bus.run && !run_q && !bus.clearALoadB;

  // The last partial product carries the multiplier's negative sign weight.
  always_comb begin
    if (cnt_q == LAST_CNT) begin
      sum = {a_q[W-1], a_q} - {s_q[W-1], s_q};
    end else begin
      sum = {a_q[W-1], a_q} + {s_q[W-1], s_q};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = bus.din;
        end else if (start) begin
          state_d = CLR;
        end
      end
      CLR: begin
        a_d     = '0;
        x_d     = 1'b0;
        s_d     = bus.din;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d   = {x_q, a_q[W-1:1]};
        b_d   = {a_q[0], b_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ADD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      run_q   <= bus.run;
      done_q  <= done_d;
    end
  end

  assign bus.xval = x_q;
  assign bus.aval = a_q;
  assign bus.bval = b_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

`ifdef MULT_OVF_EN
  logic ovf_q, ovf_d;

  // Flag a product whose upper half is more than the sign extension of the lower half.
  always_comb begin
    ovf_d = ovf_q;
    if (load || (state_q == CLR)) begin
      ovf_d = 1'b0;
    end else if (done_d) begin
      ovf_d = (a_d != {W{b_d[W-1]}});
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_multiplier_seq.sv
// Directed self-checking bench for multiplier_seq at W=8 and W=16.
// Expected products are hand-computed two's-complement values.
module tb_multiplier_seq;
`ifdef MULT_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   doneSeen;
  int   doneCycle16;

  always #5 clk = ~clk;

  multiplier_seq_if #(.W(8))  bus8 ();
  multiplier_seq_if #(.W(16)) bus16 ();

  multiplier_seq #(.W(8)) dut8 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus8)
  );

  multiplier_seq #(.W(16)) dut16 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult8(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic x, input logic ovfRaw);
    checkOutput({tag, ".A"}, 64'(bus8.aval), 64'(a));
    checkOutput({tag, ".B"}, 64'(bus8.bval), 64'(b));
    checkOutput({tag, ".X"}, 64'(bus8.xval), 64'(x));
    checkOutput({tag, ".ovf"}, 64'(bus8.ovf), 64'(OVF_EN & ovfRaw));
  endtask

  task automatic loadB8(input logic [7:0] val, input string tag);
    bus8.din         = val;
    bus8.clearALoadB = 1'b1;
    @(negedge clk);
    bus8.clearALoadB = 1'b0;
    checkOutput({tag, ".B"}, 64'(bus8.bval), 64'(val));
    checkOutput({tag, ".A"}, 64'(bus8.aval), 64'd0);
    checkOutput({tag, ".ovf"}, 64'(bus8.ovf), 64'd0);
  endtask

  // Starts a run at cycle 0 and watches cycles 1..20, then leaves Run low for a cycle.
  task automatic applyStimulus(input logic [7:0] dinVal, input int holdCycles,
                               input int changeCycle, input logic [7:0] changeVal,
                               input int clrCycle, input string tag);
    int   doneCount = 0;
    int   doneCycle = -1;
    logic busyFirst = 1'b0;
    logic busyLast  = 1'b0;
    logic busyDone  = 1'b1;
    bus8.din         = dinVal;
    bus8.run         = 1'b1;
    bus8.clearALoadB = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c == 1)  busyFirst = bus8.busy;
      if (c == 17) busyLast  = bus8.busy;
      if (c == 18) busyDone  = bus8.busy;
      if (c == changeCycle) bus8.din = changeVal;
      bus8.clearALoadB = (c == clrCycle);
      if (c >= holdCycles) bus8.run = 1'b0;
    end
    bus8.run         = 1'b0;
    bus8.clearALoadB = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({tag, ".doneCycle"}, 64'(doneCycle), 64'd18);
    checkOutput({tag, ".busyCycle1"}, 64'(busyFirst), 64'd1);
    checkOutput({tag, ".busyCycle17"}, 64'(busyLast), 64'd1);
    checkOutput({tag, ".busyDoneCycle"}, 64'(busyDone), 64'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus8.run          = 1'b0;
    bus8.clearALoadB  = 1'b0;
    bus8.din          = '0;
    bus16.run         = 1'b0;
    bus16.clearALoadB = 1'b0;
    bus16.din         = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.A", 64'(bus8.aval), 64'd0);
    checkOutput("reset.B", 64'(bus8.bval), 64'd0);
    checkOutput("reset.X", 64'(bus8.xval), 64'd0);
    checkOutput("reset.busy", 64'(bus8.busy), 64'd0);
    checkOutput("reset.done", 64'(bus8.done), 64'd0);
    checkOutput("reset.ovf", 64'(bus8.ovf), 64'd0);
    checkOutput("reset16.B", 64'(bus16.bval), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 17 * 9 = 153
    loadB8(8'h11, "load1");
    applyStimulus(8'h09, 1, 0, 8'h00, 0, "run1");
    checkResult8("run1", 8'h00, 8'h99, 1'b0, 1'b1);

    // 7 * -59 = -413
    loadB8(8'h07, "load2");
    applyStimulus(8'hC5, 1, 0, 8'h00, 0, "run2");
    checkResult8("run2", 8'hFE, 8'h63, 1'b1, 1'b1);

    // -10 * 20 = -200
    loadB8(8'hF6, "load3");
    applyStimulus(8'h14, 1, 0, 8'h00, 0, "run3");
    checkResult8("run3", 8'hFF, 8'h38, 1'b1, 1'b1);

    // -1 * -1 = 1 with Run held, then chained 1 * -1 = -1
    loadB8(8'hFF, "load4");
    applyStimulus(8'hFF, 20, 0, 8'h00, 0, "hold4");
    checkResult8("hold4", 8'h00, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1, 0, 8'h00, 0, "chain4");
    checkResult8("chain4", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // 5 * 3 with Din changed and a load pulse while busy
    loadB8(8'h05, "load5");
    applyStimulus(8'h03, 1, 4, 8'h7F, 6, "run5");
    checkResult8("run5", 8'h00, 8'h0F, 1'b0, 1'b0);

    // Reset at cycle 7 of a run aborts it silently
    loadB8(8'h05, "load6");
    bus8.din = 8'h03;
    bus8.run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus8.run = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResult8("abort", 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("abort.busy", 64'(bus8.busy), 64'd0);
    doneSeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus8.done) doneSeen++;
    end
    checkOutput("abort.noDone", 64'(doneSeen), 64'd0);

    // -3 * 6 = -18 after the abort
    loadB8(8'hFD, "load7");
    applyStimulus(8'h06, 1, 0, 8'h00, 0, "run7");
    checkResult8("run7", 8'hFF, 8'hEE, 1'b1, 1'b0);

    // Load and Run edge together: the load wins, no run starts
    bus8.din         = 8'h22;
    bus8.clearALoadB = 1'b1;
    bus8.run         = 1'b1;
    @(negedge clk);
    bus8.clearALoadB = 1'b0;
    checkOutput("tie.busy", 64'(bus8.busy), 64'd0);
    checkOutput("tie.B", 64'(bus8.bval), 64'h22);
    checkOutput("tie.A", 64'(bus8.aval), 64'd0);
    @(negedge clk);
    checkOutput("tie.heldBusy", 64'(bus8.busy), 64'd0);
    bus8.run = 1'b0;
    @(negedge clk);

    // W=16: 300 * -200 = -60000
    bus16.din         = 16'h012C;
    bus16.clearALoadB = 1'b1;
    @(negedge clk);
    bus16.clearALoadB = 1'b0;
    checkOutput("w16.load", 64'(bus16.bval), 64'h012C);
    bus16.din   = 16'hFF38;
    bus16.run   = 1'b1;
    doneCycle16 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus16.run = 1'b0;
      if (bus16.done && doneCycle16 < 0) doneCycle16 = c;
    end
    checkOutput("w16.doneCycle", 64'(doneCycle16), 64'd34);
    checkOutput("w16.A", 64'(bus16.aval), 64'hFFFF);
    checkOutput("w16.B", 64'(bus16.bval), 64'h15A0);
    checkOutput("w16.X", 64'(bus16.xval), 64'd1);
    checkOutput("w16.ovf", 64'(bus16.ovf), 64'(OVF_EN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_seq.md
# multiplier_seq

Parametrised signed sequential shift-add multiplier: W-bit multiplicand from the switch input times a W-bit multiplier register, giving a 2W+1-bit result in X:A:B. Generalises the fixed 8-bit lab multiplier in four ways:
- width parameter;
- Run edge detection, so one press gives one computation;
- multiplicand latched at start, so Din may change mid-run;
- Busy/Done status.

It sits between the switch/button synchronisers and the hex display driver. Results may be chained by pressing Run again.

## Interface
- W, 8, operand width (4..32)
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- ClearA_LoadB  in  1  synchronised button; in IDLE: A←0, X←0, B←Din
- Run  in  1  synchronised button; rising edge starts a multiply
- Din  in  W  switch input; multiplicand S or value loaded into B
- Xval  out  1  sign-extension bit X
- Aval  out  W  upper product half A
- Bval  out  W  lower product half / multiplier B
- Busy  out  1  high while a multiply is in progress
- Done  out  1  one-cycle pulse after the final shift
- Ovf  out  1  product does not fit in W bits (see Configuration)

## Operation
- States: IDLE, CLR, ADD, SHIFT. A mod-W counter cnt counts shifts.
- Start condition: Run=1, run_q=0 (run_q is Run registered every cycle), state IDLE.
  - On start: → CLR.
  - Run held high never retriggers; release and press again to chain.
- CLR: A←0, X←0, S←Din, cnt←0 → ADD.
  - B is kept, so a chained run multiplies the previous low half B by the new S.
- ADD:
  - If B[0]=1 and cnt<W-1: {X,A} ← sext(A)+sext(S), computed at W+1 bits.
  - If B[0]=1 and cnt=W-1: {X,A} ← sext(A)−sext(S). This subtract is the sign correction for a negative multiplier.
  - If B[0]=0: no change.
  - → SHIFT.
- SHIFT: {X,A,B} ← arithmetic shift right by 1; X is kept and copied into A[W-1]. cnt++.
  - cnt reaches W: → IDLE, Done=1 for that one cycle.
  - Otherwise: → ADD.
- Result: {A,B} is the 2W-bit two's-complement product. X equals A[W-1].
- ClearA_LoadB:
  - Acts only in IDLE and is level-sensitive.
  - If it is asserted in the same cycle as a Run edge, ClearA_LoadB wins and the Run edge is discarded.
  - Ignored while Busy.
- Reset: A=0, B=0, X=0, S=0, cnt=0, run_q=0, state IDLE, Busy=0, Done=0, Ovf=0. A Reset during a multiply aborts it with no Done pulse.

## Timing
- Start edge at cycle 0 (state→CLR). Busy is high cycles 1..2W+1.
- The last SHIFT completes at the edge ending cycle 2W+1. Done is high in cycle 2W+2, together with the final X/A/B.
- Busy=(state≠IDLE), decoded combinationally from the state register.
- Aval/Bval/Xval are the registers directly, with no extra latency. Intermediate values are visible while Busy.
- Earliest next start: Run low for ≥1 cycle, then high again in IDLE.

## Configuration
- MULT_OVF_EN defined:
  - Ovf is registered.
  - Cleared on Reset, on a ClearA_LoadB load, and at CLR.
  - Set in the Done cycle if A ≠ {W{B[W-1]}}, i.e. a chained run would lose precision.
  - Held until the next clear.
- Undefined: Ovf tied to 0 and no comparator is built. Port list is unchanged.

## Test plan
- W=8, load 0x11, run with Din=0x09 → A=0x00, B=0x99, X=0, Ovf=1, Done one cycle at cycle 18.
- W=8, load 0x07, run with Din=0xC5 → A=0xFE, B=0x63, X=1 (−413), Ovf=1. A second case: load 0xF6, run with Din=0x14 → A=0xFF, B=0x38, X=1 (−200).
- W=8, load 0xFF, run with Din=0xFF (Run held 20 cycles) → exactly one Done; A=0x00, B=0x01, X=0. Release Run, press again with Din=0xFF → A=0xFF, B=0xFF, X=1, Ovf=0.
- W=8, start 0x05×0x03, change Din to 0x7F at cycle 4 → result still A=0x00, B=0x0F. ClearA_LoadB pulsed while Busy → ignored.
- W=8, assert Reset at cycle 7 of a run → all outputs 0, Busy=0, no Done pulse. The next run computes correctly.
- W=16, load 0x012C (300), run with Din=0xFF38 (−200) → A=0xFFFF, B=0x15A0, X=1 (−60000), Done at cycle 34.
